// File: rtl/gate_ctrl_if.sv
// gate_ctrl_if -- signal bundle between the parking gate controller and its
// environment.
//
// Purpose : groups the request levels, vehicle code, sensor pulses and all
//           gate/occupancy status outputs of gate_ctrl into one bundle.
// Modports:
//   slave  - the controller: requests/sensors in, status out.
//   master - the environment: drives requests/sensors, observes status.
// Signals :
//   en_left/en_right     request levels from the password FSM
//   din[3:0]             vehicle code, sampled on a request edge
//   pass_left/right      vehicle crossed into that side (pulse)
//   exit_left/right      vehicle left that side (pulse)
//   gate_left/right_open barrier drives
//   count_left/right     per-side occupancy
//   full_left/right      occupancy at capacity
//   reject, timeout      single-cycle event pulses
//   last_code[3:0]       code of the last accepted request
//   state[2:0]           controller state encoding
//   rej_cnt[7:0]         saturating reject counter (GATE_REJECT_CNT_EN only)
interface gate_ctrl_if;
  logic       en_left;
  logic       en_right;
  logic [3:0] din;
  logic       pass_left;
  logic       pass_right;
  logic       exit_left;
  logic       exit_right;
  logic       gate_left_open;
  logic       gate_right_open;
  logic [3:0] count_left;
  logic [3:0] count_right;
  logic       full_left;
  logic       full_right;
  logic       reject;
  logic       timeout;
  logic [3:0] last_code;
  logic [2:0] state;
`ifdef GATE_REJECT_CNT_EN
  logic [7:0] rej_cnt;
`endif

  modport slave (
    input  en_left, en_right, din, pass_left, pass_right, exit_left, exit_right,
    output gate_left_open, gate_right_open, count_left, count_right,
           full_left, full_right, reject, timeout, last_code, state
`ifdef GATE_REJECT_CNT_EN
    , output rej_cnt
`endif
  );

  modport master (
    output en_left, en_right, din, pass_left, pass_right, exit_left, exit_right,
    input  gate_left_open, gate_right_open, count_left, count_right,
           full_left, full_right, reject, timeout, last_code, state
`ifdef GATE_REJECT_CNT_EN
    , input rej_cnt
`endif
  );
endinterface

// File: rtl/gate_ctrl.sv
// gate_ctrl -- left/right barrier gate controller behind the parking
// password FSM.
//
// Purpose : turns rising edges of en_left/en_right into a bounded gate-open
//           window, closes the gate after a vehicle passes or on timeout,
//           and tracks per-side occupancy against CAPACITY, refusing entry
//           to a full side.
// Ports   :
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - gate_ctrl_if.slave (requests, code, sensors in; gates/status out)
// Params  : CAPACITY (1..15), OPEN_CYCLES (>=2), CLOSE_CYCLES (>=1)
// Option  : define GATE_REJECT_CNT_EN to add the saturating 8-bit reject
//           counter output bus.rej_cnt.
module gate_ctrl #(
  parameter int CAPACITY     = 7,
  parameter int OPEN_CYCLES  = 16,
  parameter int CLOSE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  gate_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_OPEN_L = 3'b001;
  localparam logic [2:0] S_OPEN_R = 3'b010;
  localparam logic [2:0] S_CLOSE  = 3'b011;
  localparam logic [2:0] S_REJECT = 3'b100;

  // One timer is shared by the open window and the closing phase.
  localparam int TMAX = (OPEN_CYCLES > CLOSE_CYCLES) ? OPEN_CYCLES : CLOSE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_OPEN  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_CLOSE = TW'(CLOSE_CYCLES - 1);
  localparam logic [3:0]    CAP     = 4'(CAPACITY);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          en_left_q, en_right_q;
  logic          req_left, req_right;

  logic          gate_left_q, gate_left_d;
  logic          gate_right_q, gate_right_d;
  logic          reject_q, reject_d;
  logic          timeout_q, timeout_d;
  logic [3:0]    last_code_q, last_code_d;

  // Per-side vectors: index 0 = left, 1 = right.
  logic [1:0]    pass_v, exit_v, inc_v, full_q;
  logic [3:0]    count_q [2];
  logic [3:0]    count_d [2];

  assign req_left  = bus.en_left  & ~en_left_q;
  assign req_right = bus.en_right & ~en_right_q;
  assign pass_v    = {bus.pass_right, bus.pass_left};
  assign exit_v    = {bus.exit_right, bus.exit_left};

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      en_left_q  <= 1'b0;
      en_right_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      en_left_q  <= bus.en_left;
      en_right_q <= bus.en_right;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        // Left has priority; a simultaneous right edge is simply dropped.
        if (req_left) begin
          if (full_q[0]) begin
            state_d = S_REJECT;
          end else begin
            state_d = S_OPEN_L;
            timer_d = T_OPEN;
          end
        end else if (req_right) begin
          if (full_q[1]) begin
            state_d = S_REJECT;
          end else begin
            state_d = S_OPEN_R;
            timer_d = T_OPEN;
          end
        end
      end
      S_OPEN_L, S_OPEN_R: begin
        // A pass in the last open cycle beats the timeout.
        if (((state_q == S_OPEN_L) && bus.pass_left) ||
            ((state_q == S_OPEN_R) && bus.pass_right) ||
            (timer_q == '0)) begin
          state_d = S_CLOSE;
          timer_d = T_CLOSE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_CLOSE: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    inc_v[0]     = (state_q == S_OPEN_L) & bus.pass_left;
    inc_v[1]     = (state_q == S_OPEN_R) & bus.pass_right;
    timeout_d    = (((state_q == S_OPEN_L) & ~bus.pass_left) |
                    ((state_q == S_OPEN_R) & ~bus.pass_right)) & (timer_q == '0);
    // REJECT lasts exactly one cycle, so entering it is the pulse.
    reject_d     = (state_d == S_REJECT);
    gate_left_d  = (state_d == S_OPEN_L);
    gate_right_d = (state_d == S_OPEN_R);
    last_code_d  = last_code_q;
    if ((state_q == S_IDLE) && ((state_d == S_OPEN_L) || (state_d == S_OPEN_R))) begin
      last_code_d = bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate_left_q  <= 1'b0;
      gate_right_q <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      last_code_q  <= 4'd0;
    end else begin
      gate_left_q  <= gate_left_d;
      gate_right_q <= gate_right_d;
      reject_q     <= reject_d;
      timeout_q    <= timeout_d;
      last_code_q  <= last_code_d;
    end
  end

  // ------------------------------------------------------ per-side occupancy
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
      logic dec;

      // An exit at zero is ignored; inc and dec together cancel.
      always_comb begin
        dec         = exit_v[gi] & (count_q[gi] != 4'd0);
        count_d[gi] = count_q[gi];
        if (inc_v[gi] && !dec) begin
          if (count_q[gi] != CAP) count_d[gi] = count_q[gi] + 4'd1;
        end else if (dec && !inc_v[gi]) begin
          count_d[gi] = count_q[gi] - 4'd1;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count_q[gi] <= 4'd0;
          full_q[gi]  <= 1'b0;
        end else begin
          count_q[gi] <= count_d[gi];
          full_q[gi]  <= (count_d[gi] == CAP);
        end
      end
    end
  endgenerate

`ifdef GATE_REJECT_CNT_EN
  logic [7:0] rej_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rej_cnt_q <= 8'd0;
    end else if (reject_d && (rej_cnt_q != 8'hFF)) begin
      rej_cnt_q <= rej_cnt_q + 8'd1;
    end
  end

  assign bus.rej_cnt = rej_cnt_q;
`endif

  assign bus.state           = state_q;
  assign bus.gate_left_open  = gate_left_q;
  assign bus.gate_right_open = gate_right_q;
  assign bus.count_left      = count_q[0];
  assign bus.count_right     = count_q[1];
  assign bus.full_left       = full_q[0];
  assign bus.full_right      = full_q[1];
  assign bus.reject          = reject_q;
  assign bus.timeout         = timeout_q;
  assign bus.last_code       = last_code_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// tb_gate_ctrl -- directed bench for gate_ctrl with a cycle-level reference
// model. CAPACITY is set to 4 so that a full side, a pass+exit at count 2
// and an open gate with three vehicles parked are all reachable.
module tb_gate_ctrl;
  localparam int CAP   = 4;
  localparam int OPENC = 16;
  localparam int CLSC  = 4;

  localparam int P_IDLE = 0, P_OPENL = 1, P_OPENR = 2, P_CLOSE = 3, P_REJECT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gate_ctrl_if tif();

  gate_ctrl #(.CAPACITY(CAP), .OPEN_CYCLES(OPENC), .CLOSE_CYCLES(CLSC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tif.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  // ------------------------------------------------------ reference model
  // Phase plus "cycles already spent in this phase", counting upward.
  int m_phase = P_IDLE, m_elapsed = 0;
  int m_cnt [2] = '{0, 0};
  int m_reject = 0, m_timeout = 0, m_last = 0, m_rej = 0;
  int m_prev [2] = '{0, 0};
  int m_inc [2];
  int m_side, m_dec, m_sum;
  bit m_rl, m_rr, m_ps;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE; m_elapsed = 0; m_cnt = '{0, 0};
      m_reject = 0; m_timeout = 0; m_last = 0; m_rej = 0; m_prev = '{0, 0};
    end else begin
      m_rl = tif.en_left  && (m_prev[0] == 0);
      m_rr = tif.en_right && (m_prev[1] == 0);
      m_reject = 0; m_timeout = 0; m_inc = '{0, 0};
      case (m_phase)
        P_IDLE: begin
          if (m_rl || m_rr) begin
            m_side = m_rl ? 0 : 1;
            if (m_cnt[m_side] == CAP) begin
              m_phase = P_REJECT; m_reject = 1;
              if (m_rej < 255) m_rej++;
            end else begin
              m_phase = (m_side == 0) ? P_OPENL : P_OPENR;
              m_elapsed = 0; m_last = int'(tif.din);
            end
          end
        end
        P_OPENL, P_OPENR: begin
          m_side = (m_phase == P_OPENL) ? 0 : 1;
          m_ps = (m_side == 0) ? tif.pass_left : tif.pass_right;
          if (m_ps) begin
            m_inc[m_side] = 1; m_phase = P_CLOSE; m_elapsed = 0;
          end else if (m_elapsed == OPENC - 1) begin
            m_timeout = 1; m_phase = P_CLOSE; m_elapsed = 0;
          end else m_elapsed++;
        end
        P_CLOSE: begin
          if (m_elapsed == CLSC - 1) m_phase = P_IDLE;
          else m_elapsed++;
        end
        default: m_phase = P_IDLE;
      endcase
      for (int s = 0; s < 2; s++) begin
        m_dec = ((s == 0 ? tif.exit_left : tif.exit_right) && m_cnt[s] > 0) ? 1 : 0;
        m_sum = m_cnt[s] + m_inc[s] - m_dec;
        m_cnt[s] = (m_sum > CAP) ? CAP : m_sum;
      end
      m_prev[0] = tif.en_left ? 1 : 0;
      m_prev[1] = tif.en_right ? 1 : 0;
    end
  end

  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_state",   int'(tif.state),           m_phase);
      chk("m_gate_l",  int'(tif.gate_left_open),  (m_phase == P_OPENL) ? 1 : 0);
      chk("m_gate_r",  int'(tif.gate_right_open), (m_phase == P_OPENR) ? 1 : 0);
      chk("m_count_l", int'(tif.count_left),      m_cnt[0]);
      chk("m_count_r", int'(tif.count_right),     m_cnt[1]);
      chk("m_full_l",  int'(tif.full_left),       (m_cnt[0] == CAP) ? 1 : 0);
      chk("m_full_r",  int'(tif.full_right),      (m_cnt[1] == CAP) ? 1 : 0);
      chk("m_reject",  int'(tif.reject),          m_reject);
      chk("m_timeout", int'(tif.timeout),         m_timeout);
      chk("m_last",    int'(tif.last_code),       m_last);
`ifdef GATE_REJECT_CNT_EN
      chk("m_rej_cnt", int'(tif.rej_cnt),         m_rej);
`endif
    end
  end

  // ------------------------------------------------------ directed stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (tif.state == 3'd0) break;
      tick();
    end
    chk(name, int'(tif.state), 0);
  endtask

  task automatic enter_left(input logic [3:0] code, input logic with_exit);
    tif.en_left = 1'b1; tif.din = code;
    tick();
    tif.en_left = 1'b0;
    tick();
    tif.pass_left = 1'b1; tif.exit_left = with_exit;
    tick();
    tif.pass_left = 1'b0; tif.exit_left = 1'b0;
    wait_idle("enter_left_idle");
  endtask

  int n_high, n_to;

  initial begin
    tif.en_left = 0; tif.en_right = 0; tif.din = 0;
    tif.pass_left = 0; tif.pass_right = 0; tif.exit_left = 0; tif.exit_right = 0;
    tick(); tick();
    cmp_on = 1;
    chk("rst_state",  int'(tif.state), 0);
    chk("rst_gate_l", int'(tif.gate_left_open), 0);
    chk("rst_count",  int'(tif.count_left), 0);
    chk("rst_last",   int'(tif.last_code), 0);
    rst = 1'b1;
    tick();

    // Left pass
    tif.en_left = 1; tif.din = 4'b0101;
    tick();
    chk("l_gate_open", int'(tif.gate_left_open), 1);
    chk("l_last_code", int'(tif.last_code), 5);
    tif.en_left = 0; tif.din = 0;
    tick(); tick();
    tif.pass_left = 1;
    tick();
    tif.pass_left = 0;
    chk("l_count", int'(tif.count_left), 1);
    chk("l_close0", int'(tif.state), 3);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("l_close", int'(tif.state), 3);
    end
    tick();
    chk("l_idle", int'(tif.state), 0);

    // Right timeout
    tif.en_right = 1; tif.din = 4'b0100;
    tick();
    tif.en_right = 0;
    n_high = tif.gate_right_open ? 1 : 0;
    n_to = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tif.gate_right_open) n_high++;
      if (tif.timeout) n_to++;
      if (tif.state == 3'd0) break;
    end
    chk("r_open_cycles", n_high, 16);
    chk("r_timeouts", n_to, 1);
    chk("r_count", int'(tif.count_right), 0);
    chk("r_idle", int'(tif.state), 0);

    // Fill the left side, with a pass+exit in the same cycle at count 2
    enter_left(4'd6, 1'b0);
    chk("fill_2", int'(tif.count_left), 2);
    enter_left(4'd7, 1'b1);
    chk("pass_exit_same", int'(tif.count_left), 2);
    enter_left(4'd8, 1'b0);
    enter_left(4'd9, 1'b0);
    chk("fill_4", int'(tif.count_left), 4);
    chk("full_l", int'(tif.full_left), 1);

    // Request to a full side
    tif.en_left = 1; tif.din = 4'd3;
    tick();
    tif.en_left = 0;
    chk("rej_state",  int'(tif.state), 4);
    chk("rej_pulse",  int'(tif.reject), 1);
    chk("rej_gate",   int'(tif.gate_left_open), 0);
    chk("rej_last",   int'(tif.last_code), 9);
`ifdef GATE_REJECT_CNT_EN
    chk("rej_cnt", int'(tif.rej_cnt), 1);
`endif
    tick();
    chk("rej_back_idle", int'(tif.state), 0);
    chk("rej_pulse_end", int'(tif.reject), 0);

    // Exit at zero and a normal exit
    tif.exit_right = 1;
    tick();
    tif.exit_right = 0;
    chk("exit_at_zero", int'(tif.count_right), 0);
    tif.exit_left = 1;
    tick();
    tif.exit_left = 0;
    chk("exit_left", int'(tif.count_left), 3);

    // Simultaneous edges, then a right edge while busy
    tif.en_left = 1; tif.en_right = 1; tif.din = 4'd10;
    tick();
    chk("sim_state", int'(tif.state), 1);
    chk("sim_gate_r", int'(tif.gate_right_open), 0);
    tif.en_left = 0; tif.en_right = 0;
    tick();
    tif.en_right = 1;
    tick();
    chk("busy_state", int'(tif.state), 1);
    chk("busy_gate_r", int'(tif.gate_right_open), 0);
    chk("busy_count", int'(tif.count_left), 3);

    // Asynchronous reset in the middle of OPEN_L
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("arst_gate_l", int'(tif.gate_left_open), 0);
    chk("arst_count",  int'(tif.count_left), 0);
    chk("arst_state",  int'(tif.state), 0);
    tif.en_right = 0;
    tick();
    rst = 1;
    tick(); tick();
    chk("post_rst_idle", int'(tif.state), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
